// File: rtl/data_mem_responder_if.sv
// Request/response bundle of the rom_inf read/write protocol between the
// load/store unit (master) and the data memory responder (slave).
interface data_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_byte_num;
  logic [31:0]       rd_data;
  logic              rd_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_byte_num;
  logic [31:0]       wr_data;
  logic              wr_done;
  logic              err;

  modport master (
    output rd_en, rd_addr, rd_byte_num,
    input  rd_data, rd_done,
    output wr_en, wr_addr, wr_byte_num, wr_data,
    input  wr_done, err
  );

  modport slave (
    input  rd_en, rd_addr, rd_byte_num,
    output rd_data, rd_done,
    input  wr_en, wr_addr, wr_byte_num, wr_data,
    output wr_done, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder for the rom_inf request protocol: byte-addressed,
// little-endian memory serving one 1/2/4-byte access at a time over a
// 4-phase en/done handshake, done asserted LATENCY edges after acceptance.
// Optional MEM_BOUNDS_CHECK_EN: accesses running past DEPTH (or with an
// illegal width) are suppressed and raise a sticky err; otherwise addresses
// wrap modulo DEPTH and err is tied low.
module data_mem_responder #(
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam int QW = ADDR_W;
  localparam int CW = ADDR_W + 1;
`else
  localparam int QW = AW;
`endif

  typedef enum logic [2:0] {IDLE, RD_BUSY, WR_BUSY, RD_DONE, WR_DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [3:0]      cnt;
  logic [QW-1:0]   addr_q;
  logic [2:0]      bn_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rd_data_q;
  logic            accept_wr, accept_rd, finish;
  logic            legal;
  logic [AW-1:0]   idx [4];
  logic [31:0]     rd_word;
`ifdef MEM_BOUNDS_CHECK_EN
  logic            err_q;
`endif

  // Next-state and handshake control; a write wins over a simultaneous read.
  always_comb begin
    state_nxt = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_en) begin
          accept_wr = 1'b1;
          state_nxt = WR_BUSY;
        end else if (bus.rd_en) begin
          accept_rd = 1'b1;
          state_nxt = RD_BUSY;
        end
      end
      RD_BUSY: if (cnt == '0) begin
        finish    = 1'b1;
        state_nxt = RD_DONE;
      end
      WR_BUSY: if (cnt == '0) begin
        finish    = 1'b1;
        state_nxt = WR_DONE;
      end
      RD_DONE: if (!bus.rd_en) state_nxt = IDLE;
      WR_DONE: if (!bus.wr_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Legality of the latched access, byte lane addresses and assembled read word.
  always_comb begin
    legal   = (bn_q == 3'd1) || (bn_q == 3'd2) || (bn_q == 3'd4);
`ifdef MEM_BOUNDS_CHECK_EN
    if (({1'b0, addr_q} + CW'(bn_q)) > CW'(DEPTH)) legal = 1'b0;
`endif
    rd_word = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx[k] = addr_q[AW-1:0] + AW'(k);
      if (legal && (k < 32'(bn_q))) rd_word[8*k +: 8] = mem[idx[k]];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch, latency counter, read data and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      addr_q    <= '0;
      bn_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (accept_wr) begin
        addr_q  <= bus.wr_addr[QW-1:0];
        bn_q    <= bus.wr_byte_num;
        wdata_q <= bus.wr_data;
        cnt     <= 4'(LATENCY - 1);
      end else if (accept_rd) begin
        addr_q  <= bus.rd_addr[QW-1:0];
        bn_q    <= bus.rd_byte_num;
        cnt     <= 4'(LATENCY - 1);
      end else if ((state == RD_BUSY || state == WR_BUSY) && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish && state == RD_BUSY) rd_data_q <= rd_word;
`ifdef MEM_BOUNDS_CHECK_EN
      if (finish && !legal) err_q <= 1'b1;
`endif
    end
  end

  // Memory array is never reset; the rst guard keeps an aborted write from committing.
  always_ff @(posedge clk) begin
    if (!rst && finish && state == WR_BUSY && legal) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < 32'(bn_q)) mem[idx[k]] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.rd_done = (state == RD_DONE);
  assign bus.wr_done = (state == WR_DONE);
  assign bus.rd_data = rd_data_q;
`ifdef MEM_BOUNDS_CHECK_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a byte-array reference model
// supplies expected read data, pushed to a scoreboard queue at request time
// and popped when rd_done is observed. Honours MEM_BOUNDS_CHECK_EN if defined.
module tb_data_mem_responder;
  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 32;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model [DEPTH];
  logic [31:0] sbq [$];
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic bit model_legal(input logic [31:0] addr, input int bn);
    bit ok;
    ok = (bn == 1) || (bn == 2) || (bn == 4);
`ifdef MEM_BOUNDS_CHECK_EN
    if (longint'(addr) + longint'(bn) > longint'(DEPTH)) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int bn);
    logic [31:0] r;
    r = '0;
    if (model_legal(addr, bn))
      for (int k = 0; k < bn; k++) r[8*k +: 8] = model[(addr + k) & (DEPTH - 1)];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int bn, input logic [31:0] data);
    if (model_legal(addr, bn))
      for (int k = 0; k < bn; k++) model[(addr + k) & (DEPTH - 1)] = data[8*k +: 8];
`ifdef MEM_BOUNDS_CHECK_EN
    else exp_err = 1'b1;
`endif
  endtask

  // Counts negedges until the selected done is seen (bounded).
  task automatic wait_done(input bit is_wr, input string tag, output int n);
    for (n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (is_wr ? bus.wr_done : bus.rd_done) break;
    end
    check({tag, "_seen"}, 32'(is_wr ? bus.wr_done : bus.rd_done), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input int bn, input logic [31:0] data,
                          input int hold);
    int n;
    model_write(addr, bn, data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_byte_num = 3'(bn); bus.wr_data = data;
    wait_done(1'b1, "wr", n);
    check("wr_lat", 32'(n - 1), 32'(LAT));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("wr_hold", 32'(bus.wr_done), 32'd1);
    end
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("wr_drop", 32'(bus.wr_done), 32'd0);
    check("wr_err", 32'(bus.err), 32'(exp_err));
  endtask

  task automatic do_read(input logic [31:0] addr, input int bn, input int hold);
    int n;
    logic [31:0] exp;
    sbq.push_back(model_read(addr, bn));
    if (!model_legal(addr, bn)) begin
`ifdef MEM_BOUNDS_CHECK_EN
      exp_err = 1'b1;
`endif
    end
    bus.rd_en = 1'b1; bus.rd_addr = addr; bus.rd_byte_num = 3'(bn);
    wait_done(1'b0, "rd", n);
    check("rd_lat", 32'(n - 1), 32'(LAT));
    exp = sbq.pop_front();
    check("rd_data", bus.rd_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rd_hold_done", 32'(bus.rd_done), 32'd1);
      check("rd_hold_data", bus.rd_data, exp);
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    check("rd_drop", 32'(bus.rd_done), 32'd0);
    check("rd_keep", bus.rd_data, exp);
    check("rd_err", 32'(bus.err), 32'(exp_err));
  endtask

  // Read and write raised together: write first, read after one idle cycle.
  task automatic collision();
    int n;
    logic [31:0] exp;
    model_write(32'h30, 4, 32'hA5A5_A5A5);
    sbq.push_back(model_read(32'h30, 4));
    bus.wr_en = 1'b1; bus.wr_addr = 32'h30; bus.wr_byte_num = 3'd4; bus.wr_data = 32'hA5A5_A5A5;
    bus.rd_en = 1'b1; bus.rd_addr = 32'h30; bus.rd_byte_num = 3'd4;
    wait_done(1'b1, "coll_wr", n);
    check("coll_wr_lat", 32'(n - 1), 32'(LAT));
    check("coll_rd_wait", 32'(bus.rd_done), 32'd0);
    bus.wr_en = 1'b0;
    wait_done(1'b0, "coll_rd", n);
    check("coll_rd_lat", 32'(n), 32'(LAT + 2));
    exp = sbq.pop_front();
    check("coll_rd_data", bus.rd_data, exp);
    bus.rd_en = 1'b0;
    @(negedge clk);
    check("coll_rd_drop", 32'(bus.rd_done), 32'd0);
  endtask

  // Reset one cycle into a write: outputs clear at once, old data survives.
  task automatic reset_abort();
    bus.wr_en = 1'b1; bus.wr_addr = 32'h40; bus.wr_byte_num = 3'd4; bus.wr_data = 32'hCAFE_F00D;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_rd_done", 32'(bus.rd_done), 32'd0);
    check("rst_wr_done", 32'(bus.wr_done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    exp_err = 1'b0;
    bus.wr_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_byte_num = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_byte_num = '0; bus.wr_data = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_rd_done", 32'(bus.rd_done), 32'd0);
    check("reset_wr_done", 32'(bus.wr_done), 32'd0);
    check("reset_rd_data", bus.rd_data, 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_write(32'h10, 4, 32'hDEAD_BEEF, 0);
    do_read(32'h10, 4, 0);
    do_read(32'h12, 1, 0);
    do_read(32'h10, 2, 0);

    do_write(32'h20, 4, 32'h1122_3344, 0);
    do_write(32'h20, 1, 32'h1234_56FF, 0);
    do_read(32'h20, 4, 0);

    do_write(32'h30, 4, 32'h0, 0);
    collision();

    do_read(32'h10, 4, 3);
    do_write(32'h24, 2, 32'h0000_5A5A, 3);
    do_read(32'h24, 4, 0);

    do_write(32'h40, 4, 32'h0102_0304, 0);
    do_read(32'h40, 4, 0);
    reset_abort();
    do_read(32'h40, 4, 0);

    do_write(32'hFFC, 4, 32'h5566_7788, 0);
    do_write(32'h000, 4, 32'h99AA_BBCC, 0);
    do_write(32'hFFE, 4, 32'h4433_2211, 0);
    do_read(32'hFFC, 4, 0);
    do_read(32'h000, 4, 0);
    do_read(32'hFFF, 1, 0);
    do_read(32'h1010, 4, 0);

    do_write(32'h50, 4, 32'h0BAD_F00D, 0);
    do_write(32'h50, 3, 32'hFFFF_FFFF, 0);
    do_read(32'h50, 4, 0);
    do_read(32'h50, 3, 0);
    do_read(32'h50, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the `rom_inf` read/write request protocol that the load/store unit drives.
- Owns a byte-addressed, little-endian data memory and serves one request at a time over a 4-phase en/done handshake, with configurable access latency.
- Instantiated under the memory unit in place of the behavioural memory model.
- Serves 1-, 2- or 4-byte loads and stores. Sign or zero extension stays in the initiator.

Parameters:
- DEPTH, 4096, memory size in bytes; power of two.
- ADDR_W, 32, width of the address ports.
- LATENCY, 2, cycles from request acceptance to done; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset; asynchronous, active-high.
- rd_en  input  1  read request, held high until rd_done is seen.
- rd_addr  input  ADDR_W  byte address of the read.
- rd_byte_num  input  3  read width in bytes: 1, 2 or 4.
- rd_data  output  32  read data, zero-extended above the requested width.
- rd_done  output  1  read complete; rd_data valid while high.
- wr_en  input  1  write request, held high until wr_done is seen.
- wr_addr  input  ADDR_W  byte address of the write.
- wr_byte_num  input  3  write width in bytes: 1, 2 or 4.
- wr_data  input  32  write data; low wr_byte_num bytes are stored.
- wr_done  output  1  write committed.
- err  output  1  sticky access error; see Optional Feature.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE; rd_done=0, wr_done=0, rd_data=0, err=0, counter=0.
  - Memory array contents are not cleared.
  - Reset during an access aborts it. A pending write is not committed.
- FSM states: IDLE, RD_BUSY, WR_BUSY, RD_DONE, WR_DONE.
- IDLE:
  - wr_en=1 at edge T: latch wr_addr, wr_byte_num and wr_data; counter=LATENCY-1; go to WR_BUSY.
  - Else rd_en=1 at edge T: latch rd_addr and rd_byte_num; same counter load; go to RD_BUSY.
  - Both high: the write wins. The read is taken after the write handshake completes.
- RD_BUSY / WR_BUSY:
  - Counter decrements each edge.
  - On the edge where counter==0, which is edge T+LATENCY:
    - Write: bytes are committed and wr_done=1; go to WR_DONE.
    - Read: rd_data is loaded and rd_done=1; go to RD_DONE.
  - Request inputs are ignored after latching. Dropping en while busy does not abort the access.
- RD_DONE / WR_DONE:
  - done and rd_data are held while the matching en is high.
  - At the first edge that samples en=0: done=0 and state goes to IDLE.
  - rd_data keeps its last value until the next read completes.
  - Earliest next acceptance is the following edge, so there is at least one idle cycle between requests.
- Byte layout: byte k of the data sits at mem[(addr+k) mod DEPTH], k < byte_num, little-endian.
  - Wrap is modulo DEPTH when MEM_BOUNDS_CHECK_EN is not defined.
- Illegal byte_num (0, 3, 5..7):
  - The handshake completes normally.
  - A write modifies nothing; a read returns 0.
  - err is set only when MEM_BOUNDS_CHECK_EN is defined.
- Address bits above log2(DEPTH) are ignored when MEM_BOUNDS_CHECK_EN is not defined.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - An access with addr+byte_num > DEPTH, or with an illegal byte_num, completes its handshake at normal latency.
  - A write changes no byte; a read returns 0.
  - err is set at the done edge and stays high until rst.
- Not defined:
  - Addresses wrap modulo DEPTH.
  - err is tied to 0.

Test Plan:
- Reset, then write addr=0x10, byte_num=4, data=0xDEADBEEF, LATENCY=2 -> wr_done rises exactly 2 edges after acceptance. A following read of 0x10, 4 bytes returns 0xDEADBEEF. Reads of 0x12, 1 byte and 0x10, 2 bytes return 0x000000AD and 0x0000BEEF.
- Write 0x20, byte_num=1, data=0x123456FF over a 4-byte word preloaded with 0x11223344 -> a 4-byte read of 0x20 returns 0x112233FF; upper bytes untouched.
- rd_en and wr_en raised in the same cycle, both at addr 0x30, wr_data=0xA5A5A5A5, old content 0 -> the write completes first. The read is then served and returns 0xA5A5A5A5.
- Initiator holds en 3 cycles after done -> done stays high for those 3 cycles. It falls at the first edge that samples en=0, and a new request is accepted no earlier than the next edge.
- Assert rst one cycle into a 4-byte write to 0x40 of 0xCAFEF00D -> outputs go to 0 immediately, and a read of 0x40 returns the old value.
- MEM_BOUNDS_CHECK_EN defined, DEPTH=4096: 4-byte write at 0xFFE -> wr_done asserts, memory is unchanged, err=1 and stays 1. Without the macro, the same write stores bytes at 0xFFE, 0xFFF, 0x000 and 0x001.
